mult_sequencer: RTL and testbench

//   Multi-cycle iterative multiply controller for the 5-stage pipeline's EX stage.
//   - Accepts one multiply from EX and runs a radix-2 shift-add over WIDTH cycles.
//   - Holds the pipeline stall line high while the operation runs.
//   - Returns the full 2*WIDTH product with a one-cycle done pulse.
//   - Lets MULT/MULTU issue without a wide combinational multiplier in EX.

---
 rtl/mult_sequencer_if.sv | 27 ++
 rtl/mult_sequencer.sv | 106 ++++++++++
 tb/tb_mult_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mult_sequencer_if.sv
// Handshake and data bundle between the EX stage and the iterative multiply sequencer.
// Operand and product vectors are big-endian numbered: bit 0 is the MSB.
interface mult_sequencer_if #(
  parameter int unsigned WIDTH = 32
);

  logic                 start;
  logic                 is_signed;
  logic                 abort;
  logic [0:WIDTH-1]     opa;
  logic [0:WIDTH-1]     opb;
  logic                 busy;
  logic                 stall;
  logic                 done;
  logic [0:2*WIDTH-1]   product;

  modport master (
    output start, is_signed, abort, opa, opb,
    input  busy, stall, done, product
  );

  modport slave (
    input  start, is_signed, abort, opa, opb,
    output busy, stall, done, product
  );

endinterface

// File: rtl/mult_sequencer.sv
// Radix-2 shift-add multiply controller: one operand bit per cycle over WIDTH cycles,
// stalling the pipeline while it runs and pulsing done with the full 2*WIDTH product.
module mult_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  mult_sequencer_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [PW-1:0]      product_q, product_d;

  logic [WIDTH-1:0]   opa_v, opb_v;
  logic               opa_neg, opb_neg;
  logic [WIDTH:0]     sum;
  logic [PW-1:0]      acc_step;
  logic [PW-1:0]      result;

  // Low half of the accumulator holds the remaining multiplier bits; sum keeps the carry.
  always_comb begin
    opa_v    = bus.opa;
    opb_v    = bus.opb;
    opa_neg  = bus.is_signed & opa_v[WIDTH-1];
    opb_neg  = bus.is_signed & opb_v[WIDTH-1];
    sum      = acc_q[0] ? ({1'b0, acc_q[PW-1:WIDTH]} + {1'b0, mcand_q})
                        : {1'b0, acc_q[PW-1:WIDTH]};
    acc_step = {sum, acc_q[WIDTH-1:1]};
    result   = neg_q ? ((~acc_step) + PW'(1)) : acc_step;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    product_d = product_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          mcand_d = opa_neg ? ((~opa_v) + WIDTH'(1)) : opa_v;
          acc_d   = {WIDTH'(0), (opb_neg ? ((~opb_v) + WIDTH'(1)) : opb_v)};
          neg_d   = opa_neg ^ opb_neg;
          cnt_d   = CNT_W'(WIDTH);
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            product_d = result;
            state_d   = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  // Status lines come straight from the state register.
  assign bus.busy    = (state_q == S_RUN);
  assign bus.stall   = (state_q == S_RUN);
  assign bus.done    = (state_q == S_DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: directed corner cases plus randomized operands
// checked against a plain-arithmetic 64-bit reference.
module tb_mult_sequencer;

  localparam int unsigned W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mult_sequencer_if #(.WIDTH(W)) bus ();

  mult_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp = 64'd0;
  logic [63:0] mon_e;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      return 64'(sa * sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(bus.done), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("product", bus.product, mon_e);
        last_exp = mon_e;
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that sampled start.
  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b, input logic s,
                             input logic expect_it);
    bus.opa       = a;
    bus.opb       = b;
    bus.is_signed = s;
    bus.start     = 1'b1;
    if (expect_it) exp_q.push_back(model(a, b, s));
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int stall_cyc);
    cyc       = 1;
    stall_cyc = 0;
    while (bus.done !== 1'b1 && cyc <= 100) begin
      if (bus.stall === 1'b1 && bus.busy === 1'b1) stall_cyc++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic b2b);
    int c, sc;
    pulse_start(a, b, s, 1'b1);
    wait_done(c, sc);
    check("latency", 64'(c), 64'(W + 1));
    check("stall_cycles", 64'(sc), 64'(W));
    check("stall_in_done", 64'(bus.stall), 64'd0);
    if (!b2b) begin
      @(posedge clk); #1;
      check("done_one_cycle", 64'(bus.done), 64'd0);
    end
  endtask

  initial begin
    int          c, sc;
    logic [31:0] a, b;
    logic        s;

    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.abort     = 1'b0;
    bus.opa       = '0;
    bus.opb       = '0;

    #12;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_product", bus.product, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'd7, 32'd6, 1'b0, 1'b0);
    check("mulu_7x6", bus.product, 64'h0000_0000_0000_002A);
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    check("mult_min_sq", bus.product, 64'h4000_0000_0000_0000);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);

    // Start pulsed mid-run is ignored; then a back-to-back issue from DONE.
    pulse_start(32'd1234, 32'd5678, 1'b0, 1'b1);
    c = 1;
    while (bus.done !== 1'b1 && c <= 100) begin
      if (c == 10) begin
        bus.opa   = 32'hAAAA_5555;
        bus.opb   = 32'h1357_9BDF;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      c++;
    end
    bus.start = 1'b0;
    check("ignored_start_latency", 64'(c), 64'(W + 1));
    pulse_start(32'hFFFF_FF00, 32'd3, 1'b1, 1'b1);
    wait_done(c, sc);
    check("b2b_latency", 64'(c), 64'(W + 1));
    @(posedge clk); #1;

    // Abort at RUN cycle 15.
    pulse_start(32'h0000_DEAD, 32'h0000_BEEF, 1'b1, 1'b1);
    repeat (14) begin @(posedge clk); #1; end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_stall", 64'(bus.stall), 64'd0);
    void'(exp_q.pop_back());
    repeat (40) begin @(posedge clk); #1; end
    check("abort_product_hold", bus.product, last_exp);

    // Asynchronous reset at RUN cycle 20.
    pulse_start(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1);
    repeat (19) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", 64'(bus.busy), 64'd0);
    check("midrun_rst_stall", 64'(bus.stall), 64'd0);
    check("midrun_rst_done", 64'(bus.done), 64'd0);
    check("midrun_rst_product", bus.product, 64'd0);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'd9, 32'd9, 1'b0, 1'b0);
    check("nine_squared", bus.product, 64'd81);

    // Randomized operands, signedness and back-to-back spacing.
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: b = 32'd0;
        2: a = 32'hFFFF_FFFF;
        3: b = 32'h7FFF_FFFF;
        default: ;
      endcase
      run_op(a, b, s, 1'($urandom_range(0, 1)));
    end
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    check("outstanding_ops", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
